// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared types and constants for the clock and alarm datapath.
//   bcd_digit_t  : one BCD digit (4 bits)
//   *_MAX/*_MIN  : count limits of the standard time fields
//   bcd_to_dec() : converts a tens/ones digit pair to its binary value
// No ports (package).
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int BCD_MAX_DIGIT = 9;

    typedef logic [3:0] bcd_digit_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HR24_MAX = 23;
    localparam int HR12_MIN = 1;
    localparam int HR12_MAX = 12;

    // Result is 8 bits so that out-of-range digits (up to 15/15) still
    // convert without wrapping; this lets load validation reject them.
    function automatic logic [7:0] bcd_to_dec(input bcd_digit_t tens,
                                              input bcd_digit_t ones);
        return ({4'd0, tens} * 8'd10) + {4'd0, ones};
    endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter_if
// Control and data bundle of one BCD modulo counter.
//   en, up, load          : count enable, direction, preset strobe
//   load_ones, load_tens  : preset digits
//   ones, tens            : registered count digits
//   loop, load_err        : one-cycle wrap / rejected-load pulses
//   at_max, at_min        : decodes of the registered count
// master drives the controls, slave is the counter.
// -----------------------------------------------------------------------------
interface bcd_mod_counter_if #(
    parameter int TENS_W = 3
);
    import clock_pkg::*;

    logic              en;
    logic              up;
    logic              load;
    bcd_digit_t        load_ones;
    logic [TENS_W-1:0] load_tens;
    bcd_digit_t        ones;
    logic [TENS_W-1:0] tens;
    logic              loop;
    logic              load_err;
    logic              at_max;
    logic              at_min;

    modport master (
        output en, up, load, load_ones, load_tens,
        input  ones, tens, loop, load_err, at_max, at_min
    );

    modport slave (
        input  en, up, load, load_ones, load_tens,
        output ones, tens, loop, load_err, at_max, at_min
    );

endinterface

// File: rtl/bcd_step.sv
// -----------------------------------------------------------------------------
// bcd_step
// Combinational next-value unit of the BCD modulo counter: given the current
// digit pair and a direction it produces the neighbouring value inside
// [MIN_VAL, MAX_VAL], wrapping at either end.
//   ones_i, tens_i : current value (assumed a legal in-range BCD pair)
//   up_i           : 1 = increment, 0 = decrement
//   ones_o, tens_o : next value
//   wrap_o         : the step crossed MAX_VAL->MIN_VAL or MIN_VAL->MAX_VAL
//   is_max_o       : current value equals MAX_VAL
//   is_min_o       : current value equals MIN_VAL
// -----------------------------------------------------------------------------
module bcd_step
    import clock_pkg::*;
#(
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 59,
    parameter int unsigned TENS_W  = 3
) (
    input  bcd_digit_t        ones_i,
    input  logic [TENS_W-1:0] tens_i,
    input  logic              up_i,
    output bcd_digit_t        ones_o,
    output logic [TENS_W-1:0] tens_o,
    output logic              wrap_o,
    output logic              is_max_o,
    output logic              is_min_o
);

    localparam bcd_digit_t        MIN_ONES = bcd_digit_t'(MIN_VAL % 10);
    localparam logic [TENS_W-1:0] MIN_TENS = TENS_W'(MIN_VAL / 10);
    localparam bcd_digit_t        MAX_ONES = bcd_digit_t'(MAX_VAL % 10);
    localparam logic [TENS_W-1:0] MAX_TENS = TENS_W'(MAX_VAL / 10);
    localparam bcd_digit_t        TOP_DIG  = bcd_digit_t'(BCD_MAX_DIGIT);
    localparam logic [TENS_W-1:0] TENS_ONE = TENS_W'(1);

    assign is_max_o = (ones_i == MAX_ONES) && (tens_i == MAX_TENS);
    assign is_min_o = (ones_i == MIN_ONES) && (tens_i == MIN_TENS);

    // The range-end test comes first so a limit such as 12 or 23 wraps
    // before the plain digit carry/borrow is considered.
    always_comb begin
        ones_o = ones_i;
        tens_o = tens_i;
        wrap_o = 1'b0;
        if (up_i) begin
            if (is_max_o) begin
                ones_o = MIN_ONES;
                tens_o = MIN_TENS;
                wrap_o = 1'b1;
            end else if (ones_i == TOP_DIG) begin
                ones_o = 4'd0;
                tens_o = tens_i + TENS_ONE;
            end else begin
                ones_o = ones_i + 4'd1;
            end
        end else begin
            if (is_min_o) begin
                ones_o = MAX_ONES;
                tens_o = MAX_TENS;
                wrap_o = 1'b1;
            end else if (ones_i == 4'd0) begin
                ones_o = TOP_DIG;
                tens_o = tens_i - TENS_ONE;
            end else begin
                ones_o = ones_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD modulo counter over [MIN_VAL, MAX_VAL] with up/down count,
// validated synchronous preset and one-cycle wrap / load-error pulses.
//   signal : clock, rising edge
//   reset  : asynchronous active-high reset, value returns to MIN_VAL
//   bus    : bcd_mod_counter_if.slave (controls in, digits and flags out)
// Priority at each edge: reset > load > en > hold.
// -----------------------------------------------------------------------------
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 59,
    parameter int unsigned TENS_W  = 3
) (
    input  logic                  signal,
    input  logic                  reset,
    bcd_mod_counter_if.slave      bus
);

    localparam bcd_digit_t        RST_ONES = bcd_digit_t'(MIN_VAL % 10);
    localparam logic [TENS_W-1:0] RST_TENS = TENS_W'(MIN_VAL / 10);
    localparam bcd_digit_t        TOP_DIG  = bcd_digit_t'(BCD_MAX_DIGIT);
    localparam logic [7:0]        MIN_DEC  = 8'(MIN_VAL);
    localparam logic [7:0]        MAX_DEC  = 8'(MAX_VAL);

    bcd_digit_t        ones_q, ones_d;
    logic [TENS_W-1:0] tens_q, tens_d;
    logic              loop_q, loop_d;
    logic              load_err_q, load_err_d;

    bcd_digit_t        step_ones;
    logic [TENS_W-1:0] step_tens;
    logic              step_wrap;
    logic              is_max;
    logic              is_min;

    bcd_step #(
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL),
        .TENS_W  (TENS_W)
    ) u_step (
        .ones_i   (ones_q),
        .tens_i   (tens_q),
        .up_i     (bus.up),
        .ones_o   (step_ones),
        .tens_o   (step_tens),
        .wrap_o   (step_wrap),
        .is_max_o (is_max),
        .is_min_o (is_min)
    );

    // Load validation: both digits must be decimal and the pair in range.
    bcd_digit_t load_tens4;
    logic [7:0] load_dec;
    logic       digits_ok;
    logic       lo_ok;
    logic       hi_ok;
    logic       load_ok;

    assign load_tens4 = bcd_digit_t'(bus.load_tens);
    assign load_dec   = bcd_to_dec(load_tens4, bus.load_ones);
    assign digits_ok  = (bus.load_ones <= TOP_DIG) && (load_tens4 <= TOP_DIG);
    assign hi_ok      = (load_dec <= MAX_DEC);

    // With MIN_VAL = 0 the lower bound always holds; a literal comparison
    // against zero would be a constant expression.
    if (MIN_VAL == 0) begin : g_lo_zero
        assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
        assign lo_ok = (load_dec >= MIN_DEC);
    end

    assign load_ok = digits_ok && lo_ok && hi_ok;

    // Pulses default low so each is high for one cycle per triggering edge.
    always_comb begin
        ones_d     = ones_q;
        tens_d     = tens_q;
        loop_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (load_ok) begin
                ones_d = bus.load_ones;
                tens_d = bus.load_tens;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            ones_d = step_ones;
            tens_d = step_tens;
            loop_d = step_wrap;
        end
    end

    always_ff @(posedge signal or posedge reset) begin
        if (reset) begin
            ones_q     <= RST_ONES;
            tens_q     <= RST_TENS;
            loop_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            loop_q     <= loop_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.ones     = ones_q;
    assign bus.tens     = tens_q;
    assign bus.loop     = loop_q;
    assign bus.load_err = load_err_q;
    assign bus.at_max   = is_max;
    assign bus.at_min   = is_min;

endmodule
